ctrl_pila: RTL

CTRL_PILA -- requirements
Module: ctrl_pila

---
 rtl/ctrl_pila.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ctrl_pila.sv
// Call/return controller for a hardware return-address stack: drives the
// external stack strobes, tracks its depth and loads the PC on call/return.
module ctrl_pila #(
    parameter int PROF = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       call,
    input  logic       ret,
    input  logic [9:0] pc_act,
    input  logic [9:0] dir_salto,
    input  logic [9:0] dato_pila,
    input  logic       borra_err,
    output logic       push,
    output logic       pop,
    output logic       weSP,
    output logic [9:0] dato_push,
    output logic [9:0] pc_sig,
    output logic       carga_pc,
    output logic       ocupado,
    output logic [9:0] n_elem,
    output logic       desbordamiento,
    output logic       subdesbordamiento
);

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        APILA    = 3'd1,
        DESAPILA = 3'd2,
        LEE      = 3'd3,
        CARGA    = 3'd4
    } estado_t;

    localparam logic [9:0] PROF_MAX = 10'(PROF);

    estado_t estado;

    logic lleno;
    logic vacio;
    logic en_reposo;
    logic ev_desb;
    logic ev_subd;

    // Error events only exist in REPOSO; call has priority over ret.
    always_comb begin
        lleno     = (n_elem == PROF_MAX);
        vacio     = (n_elem == 10'd0);
        en_reposo = (estado == REPOSO);
        ev_desb   = en_reposo && call && lleno;
        ev_subd   = en_reposo && !call && ret && vacio;
    end

    // All outputs are registered: strobes are loaded on the edge that enters
    // the state they belong to, so they are valid for that whole state cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado            <= REPOSO;
            push              <= 1'b0;
            pop               <= 1'b0;
            weSP              <= 1'b0;
            dato_push         <= 10'd0;
            pc_sig            <= 10'd0;
            carga_pc          <= 1'b0;
            ocupado           <= 1'b0;
            n_elem            <= 10'd0;
            desbordamiento    <= 1'b0;
            subdesbordamiento <= 1'b0;
        end else begin
            push      <= 1'b0;
            pop       <= 1'b0;
            weSP      <= 1'b0;
            carga_pc  <= 1'b0;
            dato_push <= 10'd0;

            // A new error in the same cycle as the clear keeps the flag set.
            desbordamiento    <= (desbordamiento & ~borra_err) | ev_desb;
            subdesbordamiento <= (subdesbordamiento & ~borra_err) | ev_subd;

            case (estado)
                REPOSO: begin
                    if (call) begin
                        if (!lleno) begin
                            estado    <= APILA;
                            push      <= 1'b1;
                            weSP      <= 1'b1;
                            dato_push <= pc_act + 10'd1;
                            pc_sig    <= dir_salto;
                            n_elem    <= n_elem + 10'd1;
                            ocupado   <= 1'b1;
                        end
                    end else if (ret && !vacio) begin
                        estado  <= DESAPILA;
                        pop     <= 1'b1;
                        weSP    <= 1'b1;
                        n_elem  <= n_elem - 10'd1;
                        ocupado <= 1'b1;
                    end
                end
                APILA: begin
                    estado   <= CARGA;
                    carga_pc <= 1'b1;
                end
                DESAPILA: begin
                    estado <= LEE;
                end
                LEE: begin
                    // Stack memory output is valid one cycle after the pop.
                    pc_sig   <= dato_pila;
                    estado   <= CARGA;
                    carga_pc <= 1'b1;
                end
                CARGA: begin
                    estado  <= REPOSO;
                    ocupado <= 1'b0;
                end
                default: begin
                    estado  <= REPOSO;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule
